// File: rtl/point_encode_25519_pkg.sv
// Shared definitions for the Ed25519 point encoder and its arithmetic units.
//   P        : field prime 2^255-19
//   state_t  : encoder FSM encoding (3 bits)
//   ENC_W    : width of the compressed point encoding
//   helpers  : single-step modular add/sub/halve/reduce for operands below 2^255
package point_encode_25519_pkg;

    localparam int FE_W  = 255;
    localparam int ENC_W = 256;

    typedef logic [FE_W-1:0] fe_t;

    localparam fe_t P = {FE_W{1'b1}} - fe_t'(18);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ZCHK   = 3'd1,
        ST_INV    = 3'd2,
        ST_MUL_X  = 3'd3,
        ST_MUL_Y  = 3'd4,
        ST_CANON  = 3'd5,
        ST_FINISH = 3'd6
    } state_t;

    // One conditional subtraction; exact for any v < 2P (covers all of 0..2^255-1).
    function automatic fe_t red(fe_t v);
        return (v >= P) ? v - P : v;
    endfunction

    // a, b < P
    function automatic fe_t add_mod(fe_t a, fe_t b);
        logic [FE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[FE_W-1:0];
    endfunction

    // a, b < P
    function automatic fe_t sub_mod(fe_t a, fe_t b);
        logic [FE_W:0] s;
        if (a >= b) s = {1'b0, a} - {1'b0, b};
        else        s = {1'b0, a} + {1'b0, P} - {1'b0, b};
        return s[FE_W-1:0];
    endfunction

    // a/2 mod P: odd values get P added first so the shift is exact.
    function automatic fe_t half_mod(fe_t a);
        logic [FE_W:0] s;
        s = a[0] ? ({1'b0, a} + {1'b0, P}) : {1'b0, a};
        return s[FE_W:1];
    endfunction

endpackage

// File: rtl/point_encode_25519_if.sv
// Request/response bundle of the point encoder.
//   start, x_in, y_in, z_in : request (master drives)
//   enc, done, err, busy    : result and status (slave drives)
interface point_encode_25519_if
    import point_encode_25519_pkg::*;
();
    logic             start;
    fe_t              x_in;
    fe_t              y_in;
    fe_t              z_in;
    logic [ENC_W-1:0] enc;
    logic             done;
    logic             err;
    logic             busy;

    modport master (output start, x_in, y_in, z_in, input enc, done, err, busy);
    modport slave  (input start, x_in, y_in, z_in, output enc, done, err, busy);
endinterface

// File: rtl/inv_25519.sv
// Modular inverse r = a^-1 mod P by the binary extended Euclidean method.
//   clk, rst : clock, async active-low reset
//   start    : pulse, accepted when idle; a sampled then (must be 1..P-1)
//   r, done  : result valid from the done pulse until the next start
// Invariants: x1*a == u, x2*a == v (mod P). One halving or subtraction per
// cycle; latency depends on the operand (roughly 2..1100 cycles).
module inv_25519
    import point_encode_25519_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  fe_t  a,
    output fe_t  r,
    output logic done
);
    fe_t  u_q, u_d, v_q, v_d, x1_q, x1_d, x2_q, x2_d, r_q, r_d;
    logic run_q, run_d, done_q, done_d;

    always_comb begin
        u_d    = u_q;
        v_d    = v_q;
        x1_d   = x1_q;
        x2_d   = x2_q;
        r_d    = r_q;
        run_d  = run_q;
        done_d = 1'b0;
        if (start && !run_q) begin
            u_d   = a;
            v_d   = P;
            x1_d  = fe_t'(1);
            x2_d  = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            // u == 0 only for a == 0, which the caller never issues; exit anyway.
            if (u_q == fe_t'(1) || v_q == fe_t'(1) || u_q == '0) begin
                r_d    = (u_q == fe_t'(1)) ? x1_q : x2_q;
                run_d  = 1'b0;
                done_d = 1'b1;
            end else if (!u_q[0]) begin
                u_d  = u_q >> 1;
                x1_d = half_mod(x1_q);
            end else if (!v_q[0]) begin
                v_d  = v_q >> 1;
                x2_d = half_mod(x2_q);
            end else if (u_q >= v_q) begin
                u_d  = u_q - v_q;
                x1_d = sub_mod(x1_q, x2_q);
            end else begin
                v_d  = v_q - u_q;
                x2_d = sub_mod(x2_q, x1_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            u_q    <= '0;
            v_q    <= '0;
            x1_q   <= '0;
            x2_q   <= '0;
            r_q    <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            u_q    <= u_d;
            v_q    <= v_d;
            x1_q   <= x1_d;
            x2_q   <= x2_d;
            r_q    <= r_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign r    = r_q;
    assign done = done_q;

endmodule

// File: rtl/mul_25519.sv
// Bit-serial modular multiplier r = a*b mod P.
//   clk, rst : clock, async active-low reset
//   start    : pulse, accepted when idle; a and b sampled then
//   a, b     : any 255-bit values (a is reduced on entry)
//   r, done  : result (< P) valid from the done pulse until the next start
// Takes 255 iterations (MSB first: acc = 2*acc + b_i*a), done 256 cycles after start.
module mul_25519
    import point_encode_25519_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  fe_t  a,
    input  fe_t  b,
    output fe_t  r,
    output logic done
);
    fe_t        a_q, a_d, b_q, b_d, acc_q, acc_d, t;
    logic [7:0] cnt_q, cnt_d;
    logic       run_q, run_d, done_q, done_d;

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        t      = add_mod(acc_q, acc_q);
        if (b_q[cnt_q]) t = add_mod(t, a_q);
        if (start && !run_q) begin
            a_d   = red(a);
            b_d   = b;
            acc_d = '0;
            cnt_d = 8'd254;
            run_d = 1'b1;
        end else if (run_q) begin
            acc_d = t;
            if (cnt_q == 8'd0) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign r    = acc_q;
    assign done = done_q;

endmodule

// File: rtl/point_encode_25519.sv
// Ed25519 point compression: (X:Y:Z) -> 256-bit encoding of affine (x, y).
//   clk, rst : clock, async active-low reset
//   bus      : slave side of point_encode_25519_if
//              start/x_in/y_in/z_in in; enc/done/err/busy out
// enc = {lsb(x), y} with x, y canonical; err (with enc = 0) when Z == 0 mod P.
// One multiplier is shared: X*zi first, then Y*zi.
module point_encode_25519
    import point_encode_25519_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    point_encode_25519_if.slave bus
);
    state_t           state_q, state_d;
    fe_t              x_q, x_d, y_q, y_d, z_q, z_d, zi_q, zi_d, xr_q, xr_d, yr_q, yr_d;
    logic [ENC_W-1:0] enc_q, enc_d;
    logic             zero_q, zero_d, err_q, err_d, done_q, done_d;
    logic             inv_start_q, inv_start_d, mul_start_q, mul_start_d;
    fe_t              inv_r, mul_r;
    logic             inv_done, mul_done;

    inv_25519 u_inv (
        .clk   (clk),
        .rst   (rst),
        .start (inv_start_q),
        .a     (red(z_q)),
        .r     (inv_r),
        .done  (inv_done)
    );

    mul_25519 u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start_q),
        .a     ((state_q == ST_MUL_Y) ? y_q : x_q),
        .b     (zi_q),
        .r     (mul_r),
        .done  (mul_done)
    );

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        zi_d        = zi_q;
        xr_d        = xr_q;
        yr_d        = yr_q;
        enc_d       = enc_q;
        zero_d      = zero_q;
        err_d       = err_q;
        done_d      = 1'b0;
        inv_start_d = 1'b0;
        mul_start_d = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.start) begin
                x_d     = bus.x_in;
                y_d     = bus.y_in;
                z_d     = bus.z_in;
                err_d   = 1'b0;
                state_d = ST_ZCHK;
            end
            ST_ZCHK: begin
                // z_in < 2^255 < 2P, so 0 and P are the only multiples of P.
                zero_d = (z_q == '0) || (z_q == P);
                if ((z_q == '0) || (z_q == P)) begin
                    state_d = ST_FINISH;
                end else begin
                    inv_start_d = 1'b1;
                    state_d     = ST_INV;
                end
            end
            ST_INV: if (inv_done) begin
                zi_d        = inv_r;
                mul_start_d = 1'b1;
                state_d     = ST_MUL_X;
            end
            ST_MUL_X: if (mul_done) begin
                xr_d        = mul_r;
                mul_start_d = 1'b1;
                state_d     = ST_MUL_Y;
            end
            ST_MUL_Y: if (mul_done) begin
                yr_d    = mul_r;
                state_d = ST_CANON;
            end
            ST_CANON: begin
                xr_d    = red(xr_q);
                yr_d    = red(yr_q);
                state_d = ST_FINISH;
            end
            ST_FINISH: begin
                enc_d   = zero_q ? '0 : {xr_q[0], yr_q};
                err_d   = zero_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            zi_q        <= '0;
            xr_q        <= '0;
            yr_q        <= '0;
            enc_q       <= '0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            inv_start_q <= 1'b0;
            mul_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            zi_q        <= zi_d;
            xr_q        <= xr_d;
            yr_q        <= yr_d;
            enc_q       <= enc_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
            done_q      <= done_d;
            inv_start_q <= inv_start_d;
            mul_start_q <= mul_start_d;
        end
    end

    assign bus.enc  = enc_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
    assign bus.busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_point_encode_25519.sv
// Self-checking bench for point_encode_25519. Expected encodings come from a
// plain-arithmetic model: wide multiply with %, inversion by Fermat (z^(P-2)).
module tb_point_encode_25519;
    import point_encode_25519_pkg::*;

    localparam int BUDGET = 4000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    point_encode_25519_if bus ();

    point_encode_25519 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk) if (bus.done === 1'b1) done_cnt++;

    // ---------------- reference model ----------------
    function automatic fe_t mulm(fe_t a, fe_t b);
        logic [511:0] t;
        t = 512'(a) * 512'(b);
        t = t % 512'(P);
        return t[254:0];
    endfunction

    function automatic fe_t invm(fe_t z);
        fe_t r, e;
        r = fe_t'(1);
        e = P - fe_t'(2);
        for (int i = 254; i >= 0; i--) begin
            r = mulm(r, r);
            if (e[i]) r = mulm(r, z);
        end
        return r;
    endfunction

    task automatic ref_enc(input fe_t x, input fe_t y, input fe_t z,
                           output logic [255:0] e, output logic er);
        fe_t zr, zi, ax, ay;
        zr = z % P;
        if (zr == '0) begin
            e  = '0;
            er = 1'b1;
        end else begin
            zi = invm(zr);
            ax = mulm(x, zi);
            ay = mulm(y, zi);
            e  = {ax[0], ay};
            er = 1'b0;
        end
    endtask

    function automatic fe_t rnd_fe();
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
        return w[254:0];
    endfunction

    // ---------------- driver ----------------
    // Pulses start for one cycle, then waits (bounded) for done. lat counts
    // cycles from the start cycle to the done cycle.
    task automatic run_op(input fe_t x, input fe_t y, input fe_t z,
                          output logic [255:0] e, output logic er, output int lat,
                          output logic busy_ok, output logic err1, output logic tmo);
        @(negedge clk);
        bus.start = 1'b1;
        bus.x_in  = x;
        bus.y_in  = y;
        bus.z_in  = z;
        @(negedge clk);
        bus.start = 1'b0;
        lat     = 1;
        busy_ok = 1'b1;
        err1    = bus.err;
        tmo     = 1'b0;
        while (bus.done !== 1'b1) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (lat >= BUDGET) begin
                tmo = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        if (bus.busy !== 1'b0) busy_ok = 1'b0;
        e  = bus.enc;
        er = bus.err;
    endtask

    // ---------------- constants ----------------
    fe_t          bx;
    fe_t          by;
    logic [255:0] exp_base;
    logic [255:0] exp_sign;

    // ---------------- tests ----------------
    task automatic test_reset();
        #1 rst = 1'b0;
        #12;
        n_cmp++;
        if (bus.done !== 1'b0 || bus.err !== 1'b0 || bus.busy !== 1'b0 || bus.enc !== '0) begin
            n_bad++;
            $display("FAIL reset_state: done=%b err=%b busy=%b enc=%h want 0/0/0/0",
                     bus.done, bus.err, bus.busy, bus.enc);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_identity();
        logic [255:0] e; logic er, bok, e1, tmo; int lat, dc0;
        dc0 = done_cnt;
        run_op(fe_t'(0), fe_t'(1), fe_t'(1), e, er, lat, bok, e1, tmo);
        n_cmp++;
        if (tmo || e !== 256'h1 || er !== 1'b0) begin
            n_bad++;
            $display("FAIL identity: enc=%h err=%b tmo=%b want enc=1 err=0", e, er, tmo);
        end
        n_cmp++;
        if (bok !== 1'b1) begin
            n_bad++;
            $display("FAIL identity_busy: busy_ok=%b want 1", bok);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (done_cnt - dc0 != 1) begin
            n_bad++;
            $display("FAIL identity_done_count: got %0d want 1", done_cnt - dc0);
        end
    endtask

    task automatic test_base_point();
        logic [255:0] e; logic er, bok, e1, tmo; int lat;
        run_op(mulm(fe_t'(2), bx), mulm(fe_t'(2), by), fe_t'(2), e, er, lat, bok, e1, tmo);
        n_cmp++;
        if (tmo || e !== exp_base || er !== 1'b0) begin
            n_bad++;
            $display("FAIL base_point: enc=%h err=%b want enc=%h err=0", e, er, exp_base);
        end
    endtask

    task automatic test_sign_bit();
        logic [255:0] e; logic er, bok, e1, tmo; int lat;
        run_op(P - bx, by, fe_t'(1), e, er, lat, bok, e1, tmo);
        n_cmp++;
        if (tmo || e !== exp_sign || er !== 1'b0) begin
            n_bad++;
            $display("FAIL sign_bit: enc=%h err=%b want enc=%h err=0", e, er, exp_sign);
        end
    endtask

    task automatic test_noncanonical();
        logic [255:0] e; logic er, bok, e1, tmo; int lat;
        run_op(fe_t'(0), P + fe_t'(1), fe_t'(1), e, er, lat, bok, e1, tmo);
        n_cmp++;
        if (tmo || e !== 256'h1 || er !== 1'b0) begin
            n_bad++;
            $display("FAIL noncanon_y: enc=%h err=%b want enc=1 err=0", e, er);
        end
        run_op(fe_t'(0), fe_t'(1), P + fe_t'(1), e, er, lat, bok, e1, tmo);
        n_cmp++;
        if (tmo || e !== 256'h1 || er !== 1'b0) begin
            n_bad++;
            $display("FAIL noncanon_z: enc=%h err=%b want enc=1 err=0", e, er);
        end
    endtask

    task automatic test_zero_z();
        logic [255:0] e; logic er, bok, e1, tmo; int lat;
        fe_t zs [2];
        zs[0] = '0;
        zs[1] = P;
        for (int k = 0; k < 2; k++) begin
            run_op(rnd_fe(), rnd_fe(), zs[k], e, er, lat, bok, e1, tmo);
            n_cmp++;
            if (tmo || e !== '0 || er !== 1'b1) begin
                n_bad++;
                $display("FAIL zero_z%0d: enc=%h err=%b want enc=0 err=1", k, e, er);
            end
            n_cmp++;
            if (lat != 3 || bok !== 1'b1) begin
                n_bad++;
                $display("FAIL zero_z%0d_latency: lat=%0d busy_ok=%b want lat=3 busy_ok=1", k, lat, bok);
            end
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (bus.err !== 1'b1 || bus.enc !== '0) begin
            n_bad++;
            $display("FAIL err_hold: err=%b enc=%h want err=1 enc=0", bus.err, bus.enc);
        end
        run_op(fe_t'(0), fe_t'(1), fe_t'(1), e, er, lat, bok, e1, tmo);
        n_cmp++;
        if (e1 !== 1'b0 || tmo || e !== 256'h1 || er !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clear: err_after_start=%b enc=%h err=%b want 0/1/0", e1, e, er);
        end
    endtask

    task automatic test_reset_mid();
        logic [255:0] e; logic er, bok, e1, tmo; int lat, dc0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.x_in  = rnd_fe();
        bus.y_in  = rnd_fe();
        bus.z_in  = rnd_fe() | fe_t'(2);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_busy_before: busy=%b want 1", bus.busy);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 || bus.enc !== '0) begin
            n_bad++;
            $display("FAIL midreset_clear: busy=%b done=%b err=%b enc=%h want all 0",
                     bus.busy, bus.done, bus.err, bus.enc);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        dc0 = done_cnt;
        repeat (40) @(negedge clk);
        n_cmp++;
        if (done_cnt != dc0) begin
            n_bad++;
            $display("FAIL midreset_stale_done: got %0d pulses want 0", done_cnt - dc0);
        end
        run_op(fe_t'(0), fe_t'(1), fe_t'(1), e, er, lat, bok, e1, tmo);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (tmo || e !== 256'h1 || done_cnt - dc0 != 1) begin
            n_bad++;
            $display("FAIL midreset_after: enc=%h dones=%0d want enc=1 dones=1", e, done_cnt - dc0);
        end
    endtask

    task automatic test_busy_start();
        logic [255:0] want, wb; logic wer, werb; int n, dc0;
        fe_t ax, ay, az;
        ax = rnd_fe(); ay = rnd_fe(); az = rnd_fe() | fe_t'(1);
        ref_enc(ax, ay, az, want, wer);
        ref_enc(fe_t'(0), fe_t'(1), fe_t'(1), wb, werb);
        dc0 = done_cnt;
        @(negedge clk);
        bus.start = 1'b1; bus.x_in = ax; bus.y_in = ay; bus.z_in = az;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        bus.start = 1'b1; bus.x_in = '0; bus.y_in = fe_t'(1); bus.z_in = fe_t'(1);
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.done !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (bus.done !== 1'b1 || bus.enc !== want || bus.err !== wer) begin
            n_bad++;
            $display("FAIL busy_start_result: enc=%h err=%b want enc=%h err=%b", bus.enc, bus.err, want, wer);
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (done_cnt - dc0 != 1) begin
            n_bad++;
            $display("FAIL busy_start_dones: got %0d want 1", done_cnt - dc0);
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] e, want; logic er, wer, bok, e1, tmo; int lat, dc0;
        fe_t x, y, z;
        dc0 = done_cnt;
        for (int k = 0; k < 2; k++) begin
            x = rnd_fe(); y = rnd_fe(); z = rnd_fe();
            ref_enc(x, y, z, want, wer);
            run_op(x, y, z, e, er, lat, bok, e1, tmo);
            n_cmp++;
            if (tmo || e !== want || er !== wer || bok !== 1'b1) begin
                n_bad++;
                $display("FAIL back_to_back%0d: enc=%h err=%b busy_ok=%b want enc=%h err=%b",
                         k, e, er, bok, want, wer);
            end
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (done_cnt - dc0 != 2) begin
            n_bad++;
            $display("FAIL back_to_back_dones: got %0d want 2", done_cnt - dc0);
        end
    endtask

    task automatic test_random();
        logic [255:0] e, want; logic er, wer, bok, e1, tmo; int lat;
        fe_t x, y, z;
        for (int k = 0; k < 6; k++) begin
            x = rnd_fe(); y = rnd_fe(); z = rnd_fe();
            if (k == 4) z = P + fe_t'($urandom_range(1, 18));
            if (k == 5) z = P - fe_t'($urandom_range(1, 100));
            ref_enc(x, y, z, want, wer);
            run_op(x, y, z, e, er, lat, bok, e1, tmo);
            n_cmp++;
            if (tmo || e !== want || er !== wer) begin
                n_bad++;
                $display("FAIL random%0d: enc=%h err=%b want enc=%h err=%b", k, e, er, want, wer);
            end
        end
    endtask

    initial begin
        bx = 255'h216936d3cd6e53fec0a4e231fdd6dc5c692cc7609525a7b2c9562d608f25d51a;
        exp_base = {{31{8'h66}}, 8'h58};
        exp_sign = {8'he6, {30{8'h66}}, 8'h58};
        by = exp_base[254:0];
        bus.start = 1'b0;
        bus.x_in  = '0;
        bus.y_in  = '0;
        bus.z_in  = '0;
        test_reset();
        test_identity();
        test_base_point();
        test_sign_bit();
        test_noncanonical();
        test_zero_z();
        test_reset_mid();
        test_busy_start();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
